gshare_pred: RTL and testbench
==============================

Name: gshare_pred

Overview:
- Parametrised direction predictor for the fetch stage: a table of saturating counters, indexed by PC XOR global history (gshare) or by PC alone (bimodal).
- Lookup is combinational in the fetch cycle.
- Execute returns resolved outcomes to train the table. On a mispredict it also restores the speculative global history register (GHR).
- Generalises the single 2-bit predictor to N entries, configurable counter width, selectable hysteresis, and history.

Parameters:
- CNT_BITS, 2, width of each saturating counter (>=2)
- IDX_BITS, 4, log2 of table entries
- HIST_BITS, 4, GHR width; must satisfy 1 <= HIST_BITS <= IDX_BITS
- PC_BITS, 32, PC width
- USE_HIST, 1, 1 = gshare index, 0 = bimodal index (GHR still maintained)
- HYSTERESIS, 1, 1 = weak states jump to strong, 0 = plain up/down counting

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high
- lookup_valid  input  1  fetch is predicting a branch this cycle
- lookup_pc  input  PC_BITS  branch PC
- prediction  output  1  predicted taken
- pred_index  output  IDX_BITS  table index used; carried with the branch
- pred_hist  output  HIST_BITS  GHR value before this lookup's shift; checkpoint
- update_valid  input  1  resolved branch
- update_index  input  IDX_BITS  pred_index returned from execute
- update_taken  input  1  actual outcome
- update_mispredict  input  1  prediction was wrong
- update_hist  input  HIST_BITS  pred_hist returned from execute
- mispredict_count  output  32  saturating count of mispredicts

Behaviour:
- Interface: clock is clock; reset is reset, synchronous, active-high.
- Index:
  - pcidx = lookup_pc[IDX_BITS+1:2].
  - USE_HIST=1: pred_index = pcidx XOR zero-extended GHR.
  - USE_HIST=0: pred_index = pcidx.
- Prediction:
  - prediction = MSB of table[pred_index]; pred_hist = current GHR.
  - Purely combinational, zero latency; valid whenever lookup_pc is valid, independent of lookup_valid.
- Reset:
  - Every entry is set to weakly not-taken, 2^(CNT_BITS-1)-1 (01 for 2 bits).
  - GHR = 0 and mispredict_count = 0.
  - Consequence: prediction = 0 in the first cycle after reset.
  - Reset mid-operation discards all training and history in that one cycle and overrides any update or lookup in the same cycle.
- Counter next state on update_valid (MAX = 2^CNT_BITS-1; weak states W0 = 2^(CNT_BITS-1)-1, W1 = W0+1):
  - HYSTERESIS=1 and counter is W0 or W1: taken -> MAX, not taken -> 0.
  - Otherwise: taken -> min(c+1, MAX); not taken -> max(c-1, 0).
  - Saturation: no wrap at 0 or MAX.
  - The written counter takes effect at the next clock edge.
- Read/write ordering: a lookup in the same cycle as an update to the same index sees the old value (no bypass).
- GHR update, one change per cycle, priority order:
  1. update_valid & update_mispredict: GHR <= {update_hist[HIST_BITS-2:0], update_taken}. For HIST_BITS=1, GHR <= update_taken.
  2. Else lookup_valid: GHR <= {GHR[HIST_BITS-2:0], prediction}.
  3. Else GHR holds.
- Simultaneous lookup and mispredict: restore wins and the lookup's shift is dropped. Fetch is flushed that cycle.
- update_mispredict without update_valid is ignored.
- mispredict_count increments on update_valid & update_mispredict and saturates at 0xFFFFFFFF.
- Table is flop-based (no SRAM); single write port.

Decomposition:
- Package pred_pkg holds:
  - localparam function weak_nt(cnt_bits), returning the reset value;
  - function fold_hist, zero-extending the history to the index width;
  - typedef pred_ckpt_t {index, hist}, carried down the pipeline.
- Sub-module sat_ctr_next: combinational, parameters CNT_BITS and HYSTERESIS; maps (c, taken) to c_next. One instance on the update path.

Test Plan:
- Reset, then lookup_pc=0x44 -> pred_index=1, prediction=0, pred_hist=0; next cycle with lookup_valid=1 the GHR stays 0.
- HYSTERESIS=1, USE_HIST=0:
  - update index 5 taken -> entry 01->11, lookup pc 0x54 gives prediction=1;
  - then not taken -> 10, prediction still 1;
  - then not taken -> 00, prediction=0.
- HYSTERESIS=0: index 5 taken x3 -> 10, 11, 11 (saturates); not taken x4 -> 10, 01, 00, 00.
- USE_HIST=1, GHR=0:
  - mispredict update with update_hist=0000, taken=1 -> GHR=0001, mispredict_count=1;
  - lookup pc 0x44 -> pred_index=0;
  - lookup_valid with prediction=0 -> GHR=0010.
- Same-cycle lookup_valid and mispredict (update_hist=0101, taken=0) -> GHR=1010, lookup shift dropped. Same-cycle update to the looked-up index returns the pre-update prediction.
- Train entry 3 to 11, then assert reset while update_valid=1 -> entry 3=01, GHR=0, mispredict_count=0 the next cycle.

Source files
------------

// File: rtl/gshare_pred_pkg.sv
// Shared definitions for the gshare direction predictor.
//
// Contents:
//   MAX_W, MAX_IDX, MAX_HIST  upper bounds used for fixed-width helper types
//   weak_nt(cnt_bits)         reset value of a counter (weakly not-taken)
//   fold_hist(hist, bits)     zero-extends a history value to index width
//   pred_ckpt_t               {index, hist} checkpoint that travels with a
//                             predicted branch down to execute
package pred_pkg;

  localparam int MAX_W    = 32;
  localparam int MAX_IDX  = 16;
  localparam int MAX_HIST = 16;

  // Weakly not-taken: the state just below the taken/not-taken midpoint.
  function automatic int unsigned weak_nt(input int unsigned cnt_bits);
    return (32'd1 << (cnt_bits - 1)) - 32'd1;
  endfunction

  // Keeps only the low hist_bits of the history. Bits above the history
  // width come out as zero, so the index XOR leaves the upper PC bits alone.
  function automatic logic [MAX_W-1:0] fold_hist(input logic [MAX_W-1:0] hist,
                                                  input int unsigned hist_bits);
    logic [MAX_W-1:0] mask;
    if (hist_bits >= MAX_W) begin
      mask = '1;
    end else begin
      mask = (MAX_W'(1) << hist_bits) - MAX_W'(1);
    end
    return hist & mask;
  endfunction

  // Fixed-width checkpoint. Instances use only the low IDX_BITS / HIST_BITS.
  typedef struct packed {
    logic [MAX_IDX-1:0]  index;
    logic [MAX_HIST-1:0] hist;
  } pred_ckpt_t;

endpackage

// File: rtl/gshare_pred_if.sv
// Fetch/execute facing bus of the gshare predictor.
//
// Signal semantics: there is no back-pressure anywhere on this bus.
// lookup_valid and update_valid are single-cycle qualifiers. Each is
// consumed on the rising clock edge at which it is high. The predictor is
// always ready. prediction, pred_index and pred_hist are combinational
// functions of lookup_pc and the current state. They are meaningful
// whenever lookup_pc is, whether or not lookup_valid is high.
//
// Signals:
//   lookup_valid, lookup_pc                fetch -> predictor
//   prediction, pred_index, pred_hist      predictor -> fetch
//   update_valid, update_index, update_taken,
//   update_mispredict, update_hist         execute -> predictor
//   mispredict_count                       predictor -> observer
//
// Modports: master = fetch/execute side, slave = predictor.
interface gshare_pred_if #(
  parameter int IDX_BITS  = 4,
  parameter int HIST_BITS = 4,
  parameter int PC_BITS   = 32
);
  logic                 lookup_valid;
  logic [PC_BITS-1:0]   lookup_pc;
  logic                 prediction;
  logic [IDX_BITS-1:0]  pred_index;
  logic [HIST_BITS-1:0] pred_hist;
  logic                 update_valid;
  logic [IDX_BITS-1:0]  update_index;
  logic                 update_taken;
  logic                 update_mispredict;
  logic [HIST_BITS-1:0] update_hist;
  logic [31:0]          mispredict_count;

  modport master (
    output lookup_valid, lookup_pc,
    output update_valid, update_index, update_taken, update_mispredict, update_hist,
    input  prediction, pred_index, pred_hist, mispredict_count
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  update_valid, update_index, update_taken, update_mispredict, update_hist,
    output prediction, pred_index, pred_hist, mispredict_count
  );
endinterface

// File: rtl/gshare_pred_sat_ctr_next.sv
// Next-state function of one saturating direction counter.
//
// Parameters: CNT_BITS (counter width, >= 2), HYSTERESIS (1 = the two weak
// states jump straight to the strong state of the outcome).
// Ports:
//   c       current counter value
//   taken   resolved outcome
//   c_next  counter value to write back
module sat_ctr_next
  import pred_pkg::*;
#(
  parameter int CNT_BITS   = 2,
  parameter int HYSTERESIS = 1
) (
  input  logic [CNT_BITS-1:0] c,
  input  logic                taken,
  output logic [CNT_BITS-1:0] c_next
);

  localparam logic [CNT_BITS-1:0] MAX_VAL = '1;
  localparam logic [CNT_BITS-1:0] W0      = CNT_BITS'(weak_nt(CNT_BITS));
  localparam logic [CNT_BITS-1:0] W1      = W0 + CNT_BITS'(1);

  always_comb begin
    c_next = c;
    if ((HYSTERESIS != 0) && ((c == W0) || (c == W1))) begin
      c_next = taken ? MAX_VAL : '0;
    end else if (taken) begin
      if (c != MAX_VAL) begin
        c_next = c + CNT_BITS'(1);
      end
    end else begin
      if (c != '0) begin
        c_next = c - CNT_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/gshare_pred.sv
// Gshare / bimodal branch direction predictor.
//
// A flop-based table of 2^IDX_BITS saturating counters. Fetch looks up the
// table combinationally with lookup_pc, indexed by the word PC alone or by
// the word PC XOR global history. Execute trains one entry per cycle and,
// on a mispredict, restores the speculative global history register.
//
// Ports:
//   clock   clock
//   reset   synchronous, active-high; clears table, history and counter
//   bus     gshare_pred_if.slave (lookup, prediction, update, mispredict_count)
module gshare_pred
  import pred_pkg::*;
#(
  parameter int CNT_BITS   = 2,
  parameter int IDX_BITS   = 4,
  parameter int HIST_BITS  = 4,
  parameter int PC_BITS    = 32,
  parameter int USE_HIST   = 1,
  parameter int HYSTERESIS = 1
) (
  input  logic         clock,
  input  logic         reset,
  gshare_pred_if.slave bus
);

  localparam int                  ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] WEAK_NT = CNT_BITS'(weak_nt(CNT_BITS));

  logic [CNT_BITS-1:0]  ctr_table [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q;
  logic [HIST_BITS-1:0] ghr_next;
  logic [HIST_BITS-1:0] ghr_restore;
  logic [HIST_BITS-1:0] ghr_shift;
  logic [31:0]          mcount_q;
  logic [IDX_BITS-1:0]  pcidx;
  logic [IDX_BITS-1:0]  lookup_index;
  logic [MAX_W-1:0]     hist_ext;
  pred_ckpt_t           ckpt;
  logic                 pred_bit;
  logic                 restore;
  logic [CNT_BITS-1:0]  upd_cur;
  logic [CNT_BITS-1:0]  upd_next;
  logic                 unused_bits;

  // ---------------- lookup (combinational) ----------------
  // Branches are word aligned, so PC[1:0] carries no index information.
  assign pcidx    = bus.lookup_pc[IDX_BITS+1:2];
  assign hist_ext = fold_hist(MAX_W'(ghr_q), HIST_BITS);

  generate
    if (USE_HIST != 0) begin : g_gshare
      assign lookup_index = pcidx ^ hist_ext[IDX_BITS-1:0];
    end else begin : g_bimodal
      assign lookup_index = pcidx;
    end
  endgenerate

  // The table read sees the registered contents only. A write in this cycle
  // becomes visible after the clock edge.
  assign pred_bit = ctr_table[lookup_index][CNT_BITS-1];

  always_comb begin
    ckpt       = '0;
    ckpt.index = MAX_IDX'(lookup_index);
    ckpt.hist  = MAX_HIST'(ghr_q);
  end

  assign bus.prediction       = pred_bit;
  assign bus.pred_index       = ckpt.index[IDX_BITS-1:0];
  assign bus.pred_hist        = ckpt.hist[HIST_BITS-1:0];
  assign bus.mispredict_count = mcount_q;

  // ---------------- training path ----------------
  assign upd_cur = ctr_table[bus.update_index];

  sat_ctr_next #(
    .CNT_BITS   (CNT_BITS),
    .HYSTERESIS (HYSTERESIS)
  ) u_ctr_next (
    .c      (upd_cur),
    .taken  (bus.update_taken),
    .c_next (upd_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_table[i] <= WEAK_NT;
      end
    end else if (bus.update_valid) begin
      ctr_table[bus.update_index] <= upd_next;
    end
  end

  // ---------------- global history ----------------
  // A restore rebuilds history as it was just after the mispredicted branch
  // was fetched, with its real outcome shifted in. Fetch is being flushed in
  // that cycle, so a coincident lookup shift is dropped.
  assign restore = bus.update_valid & bus.update_mispredict;

  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_restore = bus.update_taken;
      assign ghr_shift   = pred_bit;
    end else begin : g_histn
      assign ghr_restore = {bus.update_hist[HIST_BITS-2:0], bus.update_taken};
      assign ghr_shift   = {ghr_q[HIST_BITS-2:0], pred_bit};
    end
  endgenerate

  always_comb begin
    ghr_next = ghr_q;
    if (restore) begin
      ghr_next = ghr_restore;
    end else if (bus.lookup_valid) begin
      ghr_next = ghr_shift;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ghr_q    <= '0;
      mcount_q <= '0;
    end else begin
      ghr_q <= ghr_next;
      if (restore && (mcount_q != 32'hFFFF_FFFF)) begin
        mcount_q <= mcount_q + 32'd1;
      end
    end
  end

  // Bits of the bus and helper values that the index and history do not use:
  // upper PC bits, PC[1:0], the oldest history bit on restore, and the
  // padding of the fixed-width helpers.
  assign unused_bits = ^{bus.lookup_pc, bus.update_hist, hist_ext, ckpt};

endmodule

// File: tb/tb_gshare_pred.sv
// Directed testbench for gshare_pred.
//
// Three instances share the clock, the reset and the stimulus sequence:
//   dut_a  bimodal index, hysteresis on
//   dut_b  bimodal index, plain up/down counting
//   dut_c  gshare index, hysteresis on
// Each step lists the expected value, worked out by hand, next to the
// observation.
module tb_gshare_pred;

  logic clock;
  logic reset;

  int checks   = 0;
  int failures = 0;

  gshare_pred_if if_a ();
  gshare_pred_if if_b ();
  gshare_pred_if if_c ();

  gshare_pred #(.USE_HIST(0), .HYSTERESIS(1)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (if_a.slave)
  );

  gshare_pred #(.USE_HIST(0), .HYSTERESIS(0)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (if_b.slave)
  );

  gshare_pred #(.USE_HIST(1), .HYSTERESIS(1)) dut_c (
    .clock (clock),
    .reset (reset),
    .bus   (if_c.slave)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Watchdog: the sequence is a few dozen cycles.
  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the clock edge, then move 1 time unit past it so that the
  // outputs are sampled away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    if_a.lookup_valid = 0; if_a.update_valid = 0; if_a.update_mispredict = 0;
    if_b.lookup_valid = 0; if_b.update_valid = 0; if_b.update_mispredict = 0;
    if_c.lookup_valid = 0; if_c.update_valid = 0; if_c.update_mispredict = 0;
  endtask

  task automatic upd_a(input logic [3:0] idx, input logic tk);
    if_a.update_valid = 1; if_a.update_index = idx; if_a.update_taken = tk;
    step();
    if_a.update_valid = 0;
    #1;
  endtask

  task automatic upd_b(input logic [3:0] idx, input logic tk);
    if_b.update_valid = 1; if_b.update_index = idx; if_b.update_taken = tk;
    step();
    if_b.update_valid = 0;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] b_exp [7];
    reset = 1;
    if_a.lookup_pc = '0; if_a.update_index = '0; if_a.update_taken = 0; if_a.update_hist = '0;
    if_b.lookup_pc = '0; if_b.update_index = '0; if_b.update_taken = 0; if_b.update_hist = '0;
    if_c.lookup_pc = '0; if_c.update_index = '0; if_c.update_taken = 0; if_c.update_hist = '0;
    idle_all();
    step();
    step();
    reset = 0;
    #1;

    // Reset state: pc 0x44 -> word index 0x11 -> low 4 bits = 1.
    if_a.lookup_pc = 32'h44;
    if_c.lookup_pc = 32'h44;
    #1;
    check("rst_pred_index_c", 32'(if_c.pred_index), 32'd1);
    check("rst_prediction_c", 32'(if_c.prediction), 32'd0);
    check("rst_pred_hist_c", 32'(if_c.pred_hist), 32'd0);
    check("rst_mcount_c", if_c.mispredict_count, 32'd0);
    check("rst_prediction_a", 32'(if_a.prediction), 32'd0);
    check("rst_entry0_b", 32'(dut_b.ctr_table[0]), 32'd1);

    // A lookup that predicts not-taken shifts a 0 in, so the history stays 0.
    if_c.lookup_valid = 1;
    step();
    if_c.lookup_valid = 0;
    #1;
    check("ghr_after_nt_lookup", 32'(if_c.pred_hist), 32'd0);

    // ---- dut_a: hysteresis, bimodal; pc 0x54 -> index 5 ----
    if_a.lookup_pc = 32'h54;
    #1;
    check("a_idx5_index", 32'(if_a.pred_index), 32'd5);
    upd_a(4'd5, 1'b1);   // 01 -> 11
    check("a_t_entry", 32'(dut_a.ctr_table[5]), 32'd3);
    check("a_t_pred", 32'(if_a.prediction), 32'd1);
    upd_a(4'd5, 1'b0);   // 11 -> 10
    check("a_tn_entry", 32'(dut_a.ctr_table[5]), 32'd2);
    check("a_tn_pred", 32'(if_a.prediction), 32'd1);
    upd_a(4'd5, 1'b0);   // 10 is weak -> 00
    check("a_tnn_entry", 32'(dut_a.ctr_table[5]), 32'd0);
    check("a_tnn_pred", 32'(if_a.prediction), 32'd0);
    check("a_ghr_no_lookup", 32'(if_a.pred_hist), 32'd0);

    // ---- dut_b: plain counting on index 5 ----
    if_b.lookup_pc = 32'h54;
    b_exp[0] = 2'd2; b_exp[1] = 2'd3; b_exp[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      upd_b(4'd5, 1'b1);
      check($sformatf("b_taken_%0d", i), 32'(dut_b.ctr_table[5]), 32'(b_exp[i]));
      check($sformatf("b_taken_pred_%0d", i), 32'(if_b.prediction), 32'(b_exp[i][1]));
    end
    b_exp[3] = 2'd2; b_exp[4] = 2'd1; b_exp[5] = 2'd0; b_exp[6] = 2'd0;
    for (int i = 3; i < 7; i++) begin
      upd_b(4'd5, 1'b0);
      check($sformatf("b_nt_%0d", i - 3), 32'(dut_b.ctr_table[5]), 32'(b_exp[i]));
      check($sformatf("b_nt_pred_%0d", i - 3), 32'(if_b.prediction), 32'(b_exp[i][1]));
    end
    check("b_other_entry", 32'(dut_b.ctr_table[4]), 32'd1);

    // ---- dut_c: history restore and shift ----
    // Mispredict restore, history 0000 with taken=1 -> 0001. Entry 7: 01 -> 11.
    if_c.update_valid = 1; if_c.update_mispredict = 1;
    if_c.update_index = 4'd7; if_c.update_taken = 1; if_c.update_hist = 4'b0000;
    step();
    idle_all();
    #1;
    check("c_restore_ghr", 32'(if_c.pred_hist), 32'h1);
    check("c_mcount_1", if_c.mispredict_count, 32'd1);
    // 0x44 -> pcidx 1, XOR history 1 -> index 0.
    if_c.lookup_pc = 32'h44;
    #1;
    check("c_xor_index", 32'(if_c.pred_index), 32'd0);
    check("c_xor_pred", 32'(if_c.prediction), 32'd0);
    if_c.lookup_valid = 1;
    step();
    if_c.lookup_valid = 0;
    #1;
    check("c_shift_ghr", 32'(if_c.pred_hist), 32'h2);

    // Same cycle: lookup (index 1^2 = 3), restore with 0101/taken=0, and
    // an update that trains entry 3 taken. The update uses the looked-up index.
    if_c.lookup_valid = 1;
    if_c.update_valid = 1; if_c.update_mispredict = 1;
    if_c.update_index = 4'd3; if_c.update_taken = 0; if_c.update_hist = 4'b0101;
    #1;
    check("c_same_index", 32'(if_c.pred_index), 32'd3);
    check("c_same_old_pred", 32'(if_c.prediction), 32'd0);
    step();
    idle_all();
    #1;
    check("c_restore_wins", 32'(if_c.pred_hist), 32'hA);
    check("c_mcount_2", if_c.mispredict_count, 32'd2);
    // Not taken at weak 01 -> 00.
    check("c_entry3_nt", 32'(dut_c.ctr_table[3]), 32'd0);

    // Train entry 3 to 11: 00 -> 01 -> 11 (01 is weak, jumps to strong).
    if_c.update_valid = 1; if_c.update_index = 4'd3; if_c.update_taken = 1;
    step();
    step();
    idle_all();
    #1;
    check("c_entry3_strong", 32'(dut_c.ctr_table[3]), 32'd3);
    // History is 1010 (no lookups): pc 0x24 -> pcidx 9, 9^A = 3.
    if_c.lookup_pc = 32'h24;
    #1;
    check("c_idx3_lookup", 32'(if_c.pred_index), 32'd3);
    check("c_idx3_pred", 32'(if_c.prediction), 32'd1);

    // update_mispredict without update_valid has no effect.
    if_c.update_mispredict = 1; if_c.update_taken = 1; if_c.update_hist = 4'b0011;
    step();
    idle_all();
    #1;
    check("c_ignored_ghr", 32'(if_c.pred_hist), 32'hA);
    check("c_ignored_mcount", if_c.mispredict_count, 32'd2);

    // A reset in the same cycle as a mispredicting update: the reset wins.
    reset = 1;
    if_c.update_valid = 1; if_c.update_mispredict = 1;
    if_c.update_index = 4'd3; if_c.update_taken = 1; if_c.update_hist = 4'b0111;
    if_c.lookup_valid = 1;
    step();
    reset = 0;
    idle_all();
    #1;
    check("c_rst_entry3", 32'(dut_c.ctr_table[3]), 32'd1);
    check("c_rst_ghr", 32'(if_c.pred_hist), 32'd0);
    check("c_rst_mcount", if_c.mispredict_count, 32'd0);
    if_c.lookup_pc = 32'h0C;
    #1;
    check("c_rst_pred", 32'(if_c.prediction), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
